// File: rtl/dnn_argmax_fp16.sv
// Sequential FP16 argmax over a snapshot of class scores: one compare per cycle,
// reports the winning index, its score and a confidence flag.
module dnn_argmax_fp16 #(
   parameter int                    NUM_CLASSES = 10,
   parameter int                    DATA_WIDTH  = 16,
   parameter int                    IDX_WIDTH   = 4,
   parameter logic [DATA_WIDTH-1:0] CONF_THRESH = 16'h3800
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         clear,
   input  logic signed [DATA_WIDTH-1:0] scores [NUM_CLASSES-1:0],
   output logic                         busy,
   output logic                         valid,
   output logic        [IDX_WIDTH-1:0]  digit,
   output logic        [DATA_WIDTH-1:0] max_val,
   output logic                         conf
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

   // Monotonic unsigned key for FP16 ordering: NaN lowest, both zeros equal.
   function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH-1:0] k;
      if (b[DATA_WIDTH-2 -: 5] == 5'h1F && b[DATA_WIDTH-7:0] != '0)
         k = '0;
      else if (b[DATA_WIDTH-2:0] == '0)
         k = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else if (!b[DATA_WIDTH-1])
         k = {1'b1, b[DATA_WIDTH-2:0]};
      else
         k = {1'b0, ~b[DATA_WIDTH-2:0]};
      return k;
   endfunction

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] snap [NUM_CLASSES-1:0];
   logic [IDX_WIDTH-1:0]  idx_q;
   logic [IDX_WIDTH-1:0]  best_idx_q;
   logic [DATA_WIDTH-1:0] best_q;

   logic                  win;
   logic [IDX_WIDTH-1:0]  nxt_idx;
   logic [DATA_WIDTH-1:0] nxt_best;
   logic                  launch;

   assign launch = start && !clear && (state_q != SCAN);

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      win      = 1'b0;
      nxt_idx  = best_idx_q;
      nxt_best = best_q;
      if (order_key(snap[idx_q]) > order_key(best_q)) begin
         win      = 1'b1;
         nxt_idx  = idx_q;
         nxt_best = snap[idx_q];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SCAN;
         SCAN:    if (idx_q == LAST_IDX) state_d = DONE;
         DONE:    if (start) state_d = SCAN;
         default: state_d = IDLE;
      endcase
      if (clear) state_d = IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops sample the same pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // NOTE: the snapshot is a handful of flops, not a RAM, so it is cleared on reset with everything else.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CLASSES; i++) snap[i] <= '0;
         idx_q      <= '0;
         best_idx_q <= '0;
         best_q     <= '0;
         digit      <= '0;
         max_val    <= '0;
         conf       <= 1'b0;
      end else if (clear) begin
         idx_q      <= '0;
         best_idx_q <= '0;
         best_q     <= '0;
         digit      <= '0;
         max_val    <= '0;
         conf       <= 1'b0;
      end else if (launch) begin
         for (int i = 0; i < NUM_CLASSES; i++) snap[i] <= scores[i];
         best_q     <= scores[0];
         best_idx_q <= '0;
         idx_q      <= IDX_WIDTH'(1);
      end else if (state_q == SCAN) begin
         best_q     <= nxt_best;
         best_idx_q <= nxt_idx;
         idx_q      <= idx_q + 1'b1;
         if (idx_q == LAST_IDX) begin
            digit   <= nxt_idx;
            max_val <= nxt_best;
            conf    <= order_key(nxt_best) >= order_key(CONF_THRESH);
         end
      end
   end

   assign busy  = (state_q == SCAN);
   assign valid = (state_q == DONE);

endmodule

// File: doc/dnn_argmax_fp16.md
Name: dnn_argmax_fp16

Overview:
- Classification stage directly downstream of the FP16 sigmoid output layer.
- On start, snapshots the 10 FP16 class scores and scans them sequentially, one compare per cycle.
- Reports the winning digit index, its score, and a confidence flag; holds the result until restarted or cleared.

Parameters:
NUM_CLASSES, 10, number of scores scanned; legal range 2..16
DATA_WIDTH, 16, score width in bits; IEEE-754 binary16
IDX_WIDTH, 4, width of the digit index; must satisfy 2^IDX_WIDTH >= NUM_CLASSES
CONF_THRESH, 16'h3800, FP16 confidence threshold (0.5)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse, normally the sigmoid stage's done
clear  input  1  synchronous abort/clear; overrides start
scores  input  DATA_WIDTH x NUM_CLASSES  signed logic array [NUM_CLASSES-1:0]; FP16 bit patterns
busy  output  1  high while a scan is in progress
valid  output  1  result valid; held until the next start or clear
digit  output  IDX_WIDTH  index of the maximum score
max_val  output  DATA_WIDTH  FP16 bit pattern of the winning score
conf  output  1  high when max_val >= CONF_THRESH under FP16 ordering

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy=0, valid=0, digit=0, max_val=0, conf=0; snapshot and index counter cleared.
- FSM states: IDLE, SCAN, DONE.
- IDLE, start=1 at edge k:
  - snapshot all scores into internal registers;
  - best_idx=0, best=scores[0], idx=1;
  - go to SCAN.
- SCAN:
  - Each edge compares snap[idx] against best using strictly-greater; replaces best_idx/best on a win; idx increments.
  - The edge at which idx==NUM_CLASSES-1 performs the last compare and moves to DONE.
  - Compares occur at edges k+1..k+NUM_CLASSES-1.
- DONE:
  - Entered at edge k+NUM_CLASSES-1.
  - valid=1, busy=0, with digit/max_val/conf registered on that same edge.
  - Latency: start edge to valid visible is NUM_CLASSES-1 cycles (9 by default).
- start in DONE: identical to start in IDLE; valid drops at that edge; new scan begins.
- start during SCAN: ignored; snapshot is not disturbed.
- clear=1 in any state: at the next edge go to IDLE with valid=0, busy=0, digit=0, max_val=0, conf=0. clear has priority over a simultaneous start.
- scores may change freely after the start edge; only the snapshot is used.
- FP16 compare via an ordering key:
  - sign=0: key = {1'b1, bits[14:0]};
  - sign=1: key = {1'b0, ~bits[14:0]};
  - keys compared unsigned.
  - -0 and +0 compare equal (force both to the +0 key).
  - NaN (exp=5'h1F, mant!=0) maps to the minimum key; it never wins against a non-NaN. If all entries are NaN, digit=0.
  - +Inf beats all finite values.
- Ties: the lowest index wins (strict greater-than only).
- conf uses the same ordering key; CONF_THRESH is inclusive (>=).
- busy=1 exactly in SCAN; valid=1 exactly in DONE.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset mid-scan: assert rst=0 during SCAN -> all outputs 0 immediately; after release, start with fresh scores gives a correct result.
- Basic: scores all 16'h2000 except scores[7]=16'h3B00 (0.875), pulse start -> valid rises 9 cycles later; digit=7, max_val=16'h3B00, conf=1; busy high for exactly the 9 preceding cycles.
- Ties/low confidence: scores[2]=scores[5]=16'h3400 (0.25), others 16'h0000 -> digit=2, conf=0. Then set CONF_THRESH=16'h3400 (parameter override) -> conf=1.
- Signs/special values: scores[0]=16'hBC00 (-1.0), scores[1]=16'h8000 (-0), scores[3]=16'h7E00 (NaN), others 16'h0000 -> digit=1 (±0 tie, lowest index). Then scores[9]=16'h7C00 (+Inf) -> digit=9.
- Snapshot isolation and ignored start: change scores and pulse start two cycles into SCAN -> result reflects the original scores; valid still at +9 cycles.
- Clear/restart: clear during SCAN -> IDLE next edge, valid never asserts. clear and start together in DONE -> IDLE, valid=0. Start in DONE -> valid drops next edge and a new result appears 9 cycles later.
